// File: rtl/control_unit.sv
// Decode and control path for the ARM-subset pipeline: instruction decoder, ID-stage bubble mux, EX/MEM control register.
// Optional feature macro: CU_ZERO_NOP_EN (decode 0x00000000 as an all-zero NOP).
module control_unit (
    input  logic        clk,
    input  logic        R,
    input  logic [31:0] in_instruction,
    input  logic        S,
    output logic [3:0]  ID_opcode,
    output logic        ID_AM,
    output logic        ID_S_enable,
    output logic        ID_load_instr,
    output logic        ID_RF_enable,
    output logic        ID_Size_enable,
    output logic        ID_RW_enable,
    output logic        ID_Enable_signal,
    output logic        ID_BL_instr,
    output logic        ID_B_instr,
    input  logic        in_EX_load_instr,
    input  logic        in_EX_RF_enable,
    input  logic        in_EX_Size_enable,
    input  logic        in_EX_RW_enable,
    input  logic        in_EX_Enable_signal,
    output logic        MEM_load_instr,
    output logic        MEM_RF_enable,
    output logic        MEM_Size_enable,
    output logic        MEM_RW_enable,
    output logic        MEM_Enable_signal
);

    logic [2:0] instr_class;
    logic [3:0] dec_opcode;
    logic       dec_am;
    logic       dec_s_enable;
    logic       dec_load_instr;
    logic       dec_rf_enable;
    logic       dec_size_enable;
    logic       dec_rw_enable;
    logic       dec_enable_signal;
    logic       dec_bl_instr;
    logic       dec_b_instr;
    logic       zero_nop;

    assign instr_class = in_instruction[27:25];

`ifdef CU_ZERO_NOP_EN
    assign zero_nop = (in_instruction == 32'h0000_0000);
`else
    assign zero_nop = 1'b0;
`endif

    always_comb begin
        dec_opcode        = 4'b0000;
        dec_am            = 1'b0;
        dec_s_enable      = 1'b0;
        dec_load_instr    = 1'b0;
        dec_rf_enable     = 1'b0;
        dec_size_enable   = 1'b0;
        dec_rw_enable     = 1'b0;
        dec_enable_signal = 1'b0;
        dec_bl_instr      = 1'b0;
        dec_b_instr       = 1'b0;
        if (!zero_nop) begin
            unique case (instr_class)
                3'b000, 3'b001: begin
                    dec_opcode    = in_instruction[24:21];
                    dec_am        = in_instruction[25];
                    dec_s_enable  = in_instruction[20];
                    // Compare/test opcodes (10xx) only set flags, never write back
                    dec_rf_enable = (in_instruction[24:23] != 2'b10);
                end
                3'b010, 3'b011: begin
                    if (!(instr_class[0] && in_instruction[4])) begin
                        dec_opcode        = in_instruction[23] ? 4'b0100 : 4'b0010;
                        dec_am            = ~in_instruction[25];
                        dec_enable_signal = 1'b1;
                        dec_size_enable   = in_instruction[22];
                        dec_load_instr    = in_instruction[20];
                        dec_rf_enable     = in_instruction[20];
                        dec_rw_enable     = ~in_instruction[20];
                    end
                end
                3'b101: begin
                    dec_opcode    = 4'b0100;
                    dec_bl_instr  = in_instruction[24];
                    dec_rf_enable = in_instruction[24];
                    dec_b_instr   = ~in_instruction[24];
                end
                default: begin
                end
            endcase
        end
    end

    // Bubble insertion: S forces every ID-stage control to zero
    always_comb begin
        ID_opcode        = 4'b0000;
        ID_AM            = 1'b0;
        ID_S_enable      = 1'b0;
        ID_load_instr    = 1'b0;
        ID_RF_enable     = 1'b0;
        ID_Size_enable   = 1'b0;
        ID_RW_enable     = 1'b0;
        ID_Enable_signal = 1'b0;
        ID_BL_instr      = 1'b0;
        ID_B_instr       = 1'b0;
        if (!S) begin
            ID_opcode        = dec_opcode;
            ID_AM            = dec_am;
            ID_S_enable      = dec_s_enable;
            ID_load_instr    = dec_load_instr;
            ID_RF_enable     = dec_rf_enable;
            ID_Size_enable   = dec_size_enable;
            ID_RW_enable     = dec_rw_enable;
            ID_Enable_signal = dec_enable_signal;
            ID_BL_instr      = dec_bl_instr;
            ID_B_instr       = dec_b_instr;
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            MEM_load_instr    <= 1'b0;
            MEM_RF_enable     <= 1'b0;
            MEM_Size_enable   <= 1'b0;
            MEM_RW_enable     <= 1'b0;
            MEM_Enable_signal <= 1'b0;
        end else begin
            MEM_load_instr    <= in_EX_load_instr;
            MEM_RF_enable     <= in_EX_RF_enable;
            MEM_Size_enable   <= in_EX_Size_enable;
            MEM_RW_enable     <= in_EX_RW_enable;
            MEM_Enable_signal <= in_EX_Enable_signal;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed decode/reset steps plus randomized decode and EX/MEM traffic.
// Honours CU_ZERO_NOP_EN when deciding what 0x00000000 should decode to.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        R = 1'b0;
    logic [31:0] in_instruction = 32'h0;
    logic        S = 1'b0;
    logic [3:0]  ID_opcode;
    logic        ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable;
    logic        ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr;
    logic        in_EX_load_instr = 1'b0, in_EX_RF_enable = 1'b0, in_EX_Size_enable = 1'b0;
    logic        in_EX_RW_enable = 1'b0, in_EX_Enable_signal = 1'b0;
    logic        MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal;

    int checks = 0;
    int failures = 0;

    control_unit dut (
        .clk(clk), .R(R), .in_instruction(in_instruction), .S(S),
        .ID_opcode(ID_opcode), .ID_AM(ID_AM), .ID_S_enable(ID_S_enable),
        .ID_load_instr(ID_load_instr), .ID_RF_enable(ID_RF_enable),
        .ID_Size_enable(ID_Size_enable), .ID_RW_enable(ID_RW_enable),
        .ID_Enable_signal(ID_Enable_signal), .ID_BL_instr(ID_BL_instr),
        .ID_B_instr(ID_B_instr),
        .in_EX_load_instr(in_EX_load_instr), .in_EX_RF_enable(in_EX_RF_enable),
        .in_EX_Size_enable(in_EX_Size_enable), .in_EX_RW_enable(in_EX_RW_enable),
        .in_EX_Enable_signal(in_EX_Enable_signal),
        .MEM_load_instr(MEM_load_instr), .MEM_RF_enable(MEM_RF_enable),
        .MEM_Size_enable(MEM_Size_enable), .MEM_RW_enable(MEM_RW_enable),
        .MEM_Enable_signal(MEM_Enable_signal)
    );

    always #5 clk = ~clk;

    // Bit order: opcode, AM, S, load, RF, Size, RW, Enable, BL, B
    function automatic logic [12:0] ctl(input int op, input bit am, input bit s, input bit ld,
                                        input bit rf, input bit sz, input bit rw, input bit en,
                                        input bit bl, input bit b);
        logic [3:0] op4;
        op4 = op[3:0];
        return {op4, am, s, ld, rf, sz, rw, en, bl, b};
    endfunction

    function automatic logic [12:0] model_decode(input logic [31:0] ins);
        int  cls;
        int  op;
        bit  ld;
        cls = int'(ins[27:25]);
        op  = int'(ins[24:21]);
        ld  = ins[20];
`ifdef CU_ZERO_NOP_EN
        if (ins == 32'h0) return 13'h0;
`endif
        if (cls <= 1)
            return ctl(op, ins[25], ins[20], 0, !(op >= 8 && op <= 11), 0, 0, 0, 0, 0);
        if (cls == 2 || (cls == 3 && ins[4] == 1'b0))
            return ctl(ins[23] ? 4 : 2, !ins[25], 0, ld, ld, ins[22], !ld, 1, 0, 0);
        if (cls == 5)
            return ctl(4, 0, 0, 0, ins[24], 0, 0, 0, ins[24], !ins[24]);
        return 13'h0;
    endfunction

    function automatic logic [12:0] id_bus();
        return {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable,
                ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr};
    endfunction

    function automatic logic [4:0] mem_bus();
        return {MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal};
    endfunction

    task automatic apply_stimulus(input logic [31:0] ins, input logic sel);
        in_instruction = ins;
        S = sel;
        #1;
    endtask

    task automatic drive_ex(input logic [4:0] v);
        {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable, in_EX_RW_enable,
         in_EX_Enable_signal} = v;
    endtask

    task automatic check_output(input string tag, input logic [12:0] expected);
        logic [12:0] observed;
        observed = id_bus();
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_mem(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        observed = mem_bus();
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic        sel;
        logic [4:0]  ex_val;
        logic [4:0]  mem_exp;

        $display("[TB] start");
        drive_ex(5'b11111);
        @(posedge clk); #1;
        check_mem("mem_load_ones", 5'b11111);

        // Asynchronous clear mid-cycle, held across an edge
        #2 R = 1'b1;
        #1 check_mem("reset_immediate", 5'b00000);
        @(posedge clk); #1;
        check_mem("reset_hold_edge", 5'b00000);
        @(negedge clk);
        R = 1'b0;
        #1 check_mem("reset_release_no_edge", 5'b00000);
        @(posedge clk); #1;
        check_mem("first_capture_after_reset", 5'b11111);

        apply_stimulus(32'hE091_0002, 1'b0);
        check_output("adds", ctl(4, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        apply_stimulus(32'hE351_0000, 1'b0);
        check_output("cmp_imm", ctl(10, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        apply_stimulus(32'hE5D1_2004, 1'b0);
        check_output("ldrb", ctl(4, 1, 0, 1, 1, 1, 0, 1, 0, 0));
        apply_stimulus(32'hE581_2000, 1'b0);
        check_output("str", ctl(4, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        apply_stimulus(32'hEB00_0003, 1'b0);
        check_output("bl", ctl(4, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        apply_stimulus(32'hEA00_0003, 1'b0);
        check_output("b", ctl(4, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        apply_stimulus(32'hE091_0002, 1'b1);
        check_output("bubble_adds", 13'h0);
        apply_stimulus(32'hE091_0002, 1'b0);
        check_output("bubble_release", ctl(4, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        apply_stimulus(32'hE610_0010, 1'b0);
        check_output("undef_011_bit4", 13'h0);
        apply_stimulus(32'hE810_0000, 1'b0);
        check_output("class_100", 13'h0);
        apply_stimulus(32'h0000_0000, 1'b0);
`ifdef CU_ZERO_NOP_EN
        check_output("zero_word", 13'h0);
`else
        check_output("zero_word", ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
`endif

        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 15) == 0) ins = 32'h0;
            sel = ($urandom_range(0, 3) == 0);
            apply_stimulus(ins, sel);
            check_output($sformatf("rand_decode_%0d", i), sel ? 13'h0 : model_decode(ins));
        end

        mem_exp = mem_bus() === 5'b11111 ? 5'b11111 : 5'b11111;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ex_val = 5'($urandom);
            drive_ex(ex_val);
            #1 check_mem($sformatf("mem_hold_%0d", i), mem_exp);
            @(posedge clk); #1;
            mem_exp = ex_val;
            check_mem($sformatf("mem_load_%0d", i), mem_exp);
        end

        @(negedge clk);
        drive_ex(5'b11011);
        @(posedge clk); #1;
        check_mem("mem_pattern_11011", 5'b11011);
        #2 R = 1'b1;
        #1 check_mem("reset_midcycle", 5'b00000);
        @(negedge clk);
        R = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
